// File: rtl/du_host_link.sv
// Host-side sequencer for the debug-unit UART protocol: it frames LOAD/RUN/STEP/DUMP
// commands as UART bytes and reassembles the response bytes into words.
module du_host_link #(
  parameter int NBITS          = 32,
  parameter int RESP_WORDS     = 41,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [NBITS-1:0] wr_data,
  output logic             rd_valid,
  output logic [NBITS-1:0] rd_data,
  output logic             rd_last,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  output logic             busy,
  output logic             err,
  output logic             timeout
);

  localparam int NB  = NBITS / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RWW = $clog2(RESP_WORDS + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] ACK_BYTE = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_OP, S_SEND_LEN, S_FETCH, S_SEND_BYTE, S_WAIT_ACK, S_RECV
  } state_t;

  typedef enum logic [1:0] {OP_LOAD, OP_RUN, OP_STEP, OP_DUMP} op_t;

  function automatic logic [7:0] opcode_byte(input op_t op);
    case (op)
      OP_LOAD: return 8'h4C;
      OP_RUN:  return 8'h52;
      OP_STEP: return 8'h53;
      default: return 8'h44;
    endcase
  endfunction

  state_t           state_q;
  op_t              op_q;
  logic [7:0]       len_q;
  logic [7:0]       word_cnt_q;
  logic [RWW-1:0]   resp_cnt_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [NBITS-1:0] shift_q;
  logic [TW-1:0]    timer_q;
  logic             in_flight_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic             rd_valid_q;
  logic [NBITS-1:0] rd_data_q;
  logic             rd_last_q;
  logic             err_q;
  logic             timeout_q;

  logic [NBITS-1:0] tx_shifted;
  logic [NBITS-1:0] rx_word;
  logic             byte_last;
  logic             tx_ack;
  logic             timer_expired;

  assign tx_shifted    = shift_q << 8;
  assign rx_word       = NBITS'({shift_q, rx_data});
  assign byte_last     = (byte_cnt_q == BCW'(NB - 1));
  assign tx_ack        = in_flight_q & tx_done;
  assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  // NOTE: wr_ready is decoded from the state register so a word already waiting is taken the first FETCH cycle.
  assign wr_ready  = (state_q == S_FETCH) & wr_valid;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign err       = err_q;
  assign timeout   = timeout_q;

  // NOTE: every register here is written with <= so all branches see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      len_q       <= '0;
      word_cnt_q  <= '0;
      resp_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      timer_q     <= '0;
      in_flight_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= op_t'(cmd_op);
            len_q       <= cmd_len;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            word_cnt_q  <= '0;
            resp_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            tx_start_q  <= 1'b1;
            tx_data_q   <= opcode_byte(op_t'(cmd_op));
            in_flight_q <= 1'b1;
            state_q     <= S_SEND_OP;
          end
        end

        S_SEND_OP: begin
          if (tx_ack) begin
            if (op_q == OP_LOAD) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= len_q;
              state_q    <= S_SEND_LEN;
            end else begin
              in_flight_q <= 1'b0;
              timer_q     <= '0;
              state_q     <= S_RECV;
            end
          end
        end

        S_SEND_LEN: begin
          if (tx_ack) begin
            in_flight_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= (len_q == 8'd0) ? S_WAIT_ACK : S_FETCH;
          end
        end

        S_FETCH: begin
          if (wr_valid) begin
            shift_q     <= wr_data;
            tx_data_q   <= wr_data[NBITS-1 -: 8];
            tx_start_q  <= 1'b1;
            in_flight_q <= 1'b1;
            byte_cnt_q  <= '0;
            state_q     <= S_SEND_BYTE;
          end
        end

        S_SEND_BYTE: begin
          if (tx_ack) begin
            if (!byte_last) begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              shift_q    <= tx_shifted;
              tx_data_q  <= tx_shifted[NBITS-1 -: 8];
              tx_start_q <= 1'b1;
            end else begin
              in_flight_q <= 1'b0;
              // Word counter stops at the last word rather than wrapping past len 255.
              if (word_cnt_q == len_q - 8'd1) begin
                timer_q <= '0;
                state_q <= S_WAIT_ACK;
              end else begin
                word_cnt_q <= word_cnt_q + 8'd1;
                state_q    <= S_FETCH;
              end
            end
          end
        end

        S_WAIT_ACK: begin
          if (rx_done) begin
            err_q   <= (rx_data != ACK_BYTE);
            state_q <= S_IDLE;
          end else if (timer_expired) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_RECV: begin
          if (rx_done) begin
            timer_q <= '0;
            if (byte_last) begin
              byte_cnt_q <= '0;
              rd_valid_q <= 1'b1;
              rd_data_q  <= rx_word;
              rd_last_q  <= (resp_cnt_q == RWW'(RESP_WORDS - 1));
              if (resp_cnt_q == RWW'(RESP_WORDS - 1)) begin
                state_q <= S_IDLE;
              end else begin
                resp_cnt_q <= resp_cnt_q + 1'b1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              shift_q    <= rx_word;
            end
          end else if (timer_expired) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
